// File: rtl/inemo_pkg.sv
// inemo_pkg: shared types and constants for the iNEMO sequencing controller.
//   state_t      - controller FSM states
//   CFG_CMD0..2  - configuration register writes issued after power-on
//   RD_BASE      - first data register of the ten-byte burst read
//   RD_CNT       - number of bytes in one burst read
//   cfg_cmd()    - configuration command word for a given index
//   rd_cmd()     - burst-read command word for a given byte index
package inemo_pkg;

    typedef enum logic [2:0] {
        WAIT_POR,
        CFG_ISSUE,
        CFG_WAIT,
        IDLE_INT,
        RD_ISSUE,
        RD_WAIT,
        UPDATE
    } state_t;

    localparam logic [15:0] CFG_CMD0   = 16'h0D02;
    localparam logic [15:0] CFG_CMD1   = 16'h1062;
    localparam logic [15:0] CFG_CMD2   = 16'h1162;
    localparam int          CFG_CNT    = 3;
    localparam logic [6:0]  RD_BASE    = 7'h22;
    localparam int          RD_CNT     = 10;
    localparam int          SAMPLE_CNT = RD_CNT / 2;

    function automatic logic [15:0] cfg_cmd(input logic [3:0] idx);
        case (idx)
            4'd0:    return CFG_CMD0;
            4'd1:    return CFG_CMD1;
            default: return CFG_CMD2;
        endcase
    endfunction

    // Bit 15 set selects a read; the address sits in [14:8], [7:0] is don't-care.
    function automatic logic [15:0] rd_cmd(input logic [3:0] idx);
        logic [6:0] addr;
        addr = RD_BASE + {3'b000, idx};
        return {1'b1, addr, 8'h00};
    endfunction

endpackage

// File: rtl/inemo_if.sv
// inemo_if: command port between the iNEMO controller and the SPI master.
//   wrt     - one-cycle transaction start strobe (controller -> SPI)
//   cmd     - 16-bit command word, stable from wrt until done (controller -> SPI)
//   done    - one-cycle transaction-complete pulse (SPI -> controller)
//   rd_data - received word, valid on the done cycle (SPI -> controller)
interface inemo_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, cmd, input done, rd_data);
    modport slave  (input wrt, cmd, output done, rd_data);
endinterface

// File: rtl/inemo_int_sync.sv
// inemo_int_sync: two-flop synchronizer for the asynchronous sensor interrupt.
//   clk      - system clock
//   rst      - synchronous active-high reset, clears both flops
//   async_in - raw interrupt from the sensor pin
//   sync_out - interrupt resynchronized to clk (two cycles of latency)
module inemo_int_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], async_in};
        end
    end

    assign sync_out = sync_reg[1];

endmodule

// File: rtl/inemo_ctrl.sv
// inemo_ctrl: power-on, configuration and interrupt-driven burst-read sequencer
// for the iNEMO inertial sensor, driving the SPI master command port.
//   clk, rst                - system clock, synchronous active-high reset
//   INT                     - asynchronous sensor interrupt
//   bus                     - SPI master command port (wrt/cmd out, done/rd_data in)
//   ptch, roll, yaw, ax, ay - latest assembled 16-bit samples {high, low}
//   vld                     - one-cycle pulse when all five samples update
//   cfg_done                - sticky flag, configuration writes complete
module inemo_ctrl
    import inemo_pkg::*;
#(
    parameter int unsigned POR_WAIT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           INT,
    inemo_if.master        bus,
    output logic [15:0]    ptch,
    output logic [15:0]    roll,
    output logic [15:0]    yaw,
    output logic [15:0]    ax,
    output logic [15:0]    ay,
    output logic           vld,
    output logic           cfg_done
);

    state_t                state_reg, state_next;
    logic [3:0]            idx_reg, idx_next;
    logic [POR_WAIT_W-1:0] por_cnt_reg;
    logic                  cfg_done_reg;
    logic                  cfg_done_set;
    logic                  vld_reg;
    logic                  shadow_we;
    logic                  wrt_c;
    logic [15:0]           cmd_c;
    logic                  int_sync;
    logic [7:0]            shadow_reg [RD_CNT];
    logic [15:0]           sample_val [SAMPLE_CNT];

    inemo_int_sync u_int_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (INT),
        .sync_out (int_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= WAIT_POR;
            idx_reg      <= 4'd0;
            por_cnt_reg  <= '0;
            cfg_done_reg <= 1'b0;
            vld_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            if (state_reg == WAIT_POR) begin
                por_cnt_reg <= por_cnt_reg + POR_WAIT_W'(1);
            end
            if (cfg_done_set) begin
                cfg_done_reg <= 1'b1;
            end
            vld_reg <= (state_reg == UPDATE);
        end
    end

    // cmd follows state/idx, so it holds steady for the whole ISSUE+WAIT
    // span and idx only advances on the done edge.
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        cfg_done_set = 1'b0;
        shadow_we    = 1'b0;
        wrt_c        = 1'b0;
        cmd_c        = 16'h0000;
        case (state_reg)
            WAIT_POR: begin
                if (&por_cnt_reg) begin
                    state_next = CFG_ISSUE;
                end
            end
            CFG_ISSUE: begin
                wrt_c      = 1'b1;
                cmd_c      = cfg_cmd(idx_reg);
                state_next = CFG_WAIT;
            end
            CFG_WAIT: begin
                cmd_c = cfg_cmd(idx_reg);
                if (bus.done) begin
                    if (idx_reg == 4'(CFG_CNT - 1)) begin
                        idx_next     = 4'd0;
                        cfg_done_set = 1'b1;
                        state_next   = IDLE_INT;
                    end else begin
                        idx_next   = idx_reg + 4'd1;
                        state_next = CFG_ISSUE;
                    end
                end
            end
            IDLE_INT: begin
                if (int_sync) begin
                    state_next = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                wrt_c      = 1'b1;
                cmd_c      = rd_cmd(idx_reg);
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                cmd_c = rd_cmd(idx_reg);
                if (bus.done) begin
                    shadow_we = 1'b1;
                    if (idx_reg == 4'(RD_CNT - 1)) begin
                        idx_next   = 4'd0;
                        state_next = UPDATE;
                    end else begin
                        idx_next   = idx_reg + 4'd1;
                        state_next = RD_ISSUE;
                    end
                end
            end
            UPDATE: begin
                state_next = IDLE_INT;
            end
            default: begin
                state_next = WAIT_POR;
            end
        endcase
    end

    // Bytes collect in a shadow file so outputs only ever change as a set.
    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow_reg[idx_reg] <= bus.rd_data[7:0];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SAMPLE_CNT; gi++) begin : g_sample
            logic [15:0] sample_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sample_reg <= 16'h0000;
                end else if (state_reg == UPDATE) begin
                    sample_reg <= {shadow_reg[2*gi+1], shadow_reg[2*gi]};
                end
            end
            assign sample_val[gi] = sample_reg;
        end
    endgenerate

    assign bus.wrt  = wrt_c;
    assign bus.cmd  = cmd_c;
    assign ptch     = sample_val[0];
    assign roll     = sample_val[1];
    assign yaw      = sample_val[2];
    assign ax       = sample_val[3];
    assign ay       = sample_val[4];
    assign vld      = vld_reg;
    assign cfg_done = cfg_done_reg;

endmodule

// File: tb/tb_inemo_ctrl.sv
// tb_inemo_ctrl: scoreboard bench for inemo_ctrl with a behavioural SPI/sensor model.
module tb_inemo_ctrl;

    localparam int W          = 4;
    localparam int POR_CYCLES = 1 << W;

    typedef logic [9:0][7:0]  burst_t;
    typedef logic [4:0][15:0] samp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        int_in = 1'b0;
    logic [15:0] ptch, roll, yaw, ax, ay;
    logic        vld, cfg_done;
    logic        slv_done = 1'b0;
    logic        stray_done = 1'b0;
    logic [15:0] slv_rd = 16'h0000;

    always #5 clk = ~clk;

    inemo_if bus ();
    assign bus.done    = slv_done | stray_done;
    assign bus.rd_data = slv_rd;

    inemo_ctrl #(.POR_WAIT_W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .INT      (int_in),
        .bus      (bus),
        .ptch     (ptch),
        .roll     (roll),
        .yaw      (yaw),
        .ax       (ax),
        .ay       (ay),
        .vld      (vld),
        .cfg_done (cfg_done)
    );

    logic [15:0] cmd_exp [$];
    samp_t       samp_exp [$];
    burst_t      data_q [$];

    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    logic rst_at_edge = 1'b1;
    int   spi_lat = 20;
    int   wrt_cnt = 0;
    int   vld_cnt = 0;
    int   rst_rel_cyc = 0;
    int   first_rd_exp_cyc = -1;
    bit   b2b_mode = 1'b0;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // SPI master + sensor model: done arrives spi_lat cycles after wrt; read
    // data comes from the burst at the head of data_q, taken on the 0x22 read.
    initial begin : spi_model
        logic [15:0] c;
        burst_t      cur;
        int          k;
        int          lat;
        logic [7:0]  rbyte;
        cur = '0;
        forever begin
            @(negedge clk);
            if (bus.wrt) begin
                c   = bus.cmd;
                lat = spi_lat;
                rbyte = 8'($urandom);
                if (c[15]) begin
                    k = int'(c[14:8]) - 'h22;
                    if (k == 0) cur = (data_q.size() > 0) ? data_q.pop_front() : '0;
                    if (k >= 0 && k < 10) rbyte = cur[k];
                end
                repeat (lat) @(posedge clk);
                #1;
                slv_done = 1'b1;
                slv_rd   = {8'($urandom), rbyte};
                @(posedge clk);
                #1;
                slv_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT strobes wrt or vld.
    initial begin : monitor
        logic        prev_wrt, prev_vld, prev_cfg;
        logic [15:0] last_cmd, e;
        int          last_done_cyc, rd9_done_cyc, cfg3_done_cyc;
        samp_t       cur_samp, model_out;
        prev_wrt = 0; prev_vld = 0; prev_cfg = 0; last_cmd = 0;
        last_done_cyc = -100; rd9_done_cyc = -100; cfg3_done_cyc = -100;
        model_out = '0;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                cur_samp = {ay, ax, yaw, roll, ptch};
                if (rst_at_edge) begin
                    chk("reset_ctl", {bus.wrt, vld, cfg_done, bus.cmd}, '0);
                    chk("reset_samples", cur_samp, '0);
                    model_out = '0;
                    last_cmd  = 16'h0000;
                end else begin
                    if (bus.done) begin
                        last_done_cyc = cyc;
                        if (last_cmd == 16'hAB00) rd9_done_cyc = cyc;
                        if (last_cmd == 16'h1162) cfg3_done_cyc = cyc;
                    end
                    if (bus.wrt) begin
                        wrt_cnt++;
                        chk("wrt_width", prev_wrt, 0);
                        if (cmd_exp.size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("FAIL unexpected_wrt: got cmd %h, required no wrt (cycle %0d)", bus.cmd, cyc);
                        end else begin
                            e = cmd_exp.pop_front();
                            chk("cmd", bus.cmd, e);
                            if (e == 16'h0D02) begin
                                chk("por_delay", cyc - rst_rel_cyc, POR_CYCLES);
                            end else if (e == 16'hA200) begin
                                if (first_rd_exp_cyc >= 0) begin
                                    chk("first_rd_delay", cyc, first_rd_exp_cyc);
                                    first_rd_exp_cyc = -1;
                                end
                            end else begin
                                chk("done_to_wrt", cyc - last_done_cyc, 1);
                            end
                        end
                        last_cmd = bus.cmd;
                    end
                    if (cfg_done && !prev_cfg) chk("cfg_done_delay", cyc - cfg3_done_cyc, 1);
                    if (prev_cfg) chk("cfg_done_sticky", cfg_done, 1);
                    if (vld) begin
                        vld_cnt++;
                        chk("vld_width", prev_vld, 0);
                        chk("vld_delay", cyc - rd9_done_cyc, 2);
                        if (samp_exp.size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("FAIL unexpected_vld: got samples %h, required no vld (cycle %0d)", cur_samp, cyc);
                        end else begin
                            model_out = samp_exp.pop_front();
                            chk("samples", cur_samp, model_out);
                        end
                        if (b2b_mode) first_rd_exp_cyc = cyc + 1;
                    end else begin
                        chk("samples_hold", cur_samp, model_out);
                    end
                end
                prev_wrt = bus.wrt;
                prev_vld = vld;
                prev_cfg = cfg_done;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_wrt(input int target, input int limit);
        int n = 0;
        while (wrt_cnt < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("wrt_wait", wrt_cnt >= target, 1);
    endtask

    task automatic wait_vld(input int target, input int limit);
        int n = 0;
        while (vld_cnt < target && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("vld_wait", vld_cnt >= target, 1);
    endtask

    task automatic wait_cfg(input int limit);
        int n = 0;
        while (!cfg_done && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("cfg_wait", cfg_done, 1);
    endtask

    task automatic push_cfg();
        cmd_exp.push_back(16'h0D02);
        cmd_exp.push_back(16'h1062);
        cmd_exp.push_back(16'h1162);
    endtask

    // Reference: read k targets 0x22+k; sample i = {byte 2i+1, byte 2i}.
    task automatic push_burst(input burst_t b, input bit expect_vld, input int ncmd);
        samp_t s;
        data_q.push_back(b);
        for (int k = 0; k < ncmd; k++) cmd_exp.push_back(16'(16'hA200 + (k << 8)));
        if (expect_vld) begin
            for (int i = 0; i < 5; i++) s[i] = {b[2*i+1], b[2*i]};
            samp_exp.push_back(s);
        end
    endtask

    function automatic burst_t rand_burst();
        burst_t b;
        for (int k = 0; k < 10; k++) b[k] = 8'($urandom);
        return b;
    endfunction

    task automatic run_burst(input burst_t b);
        int v, s;
        push_burst(b, 1'b1, 10);
        v = vld_cnt;
        s = wrt_cnt;
        int_in = 1'b1;
        first_rd_exp_cyc = cyc + 3;
        wait_wrt(s + 1, 100);
        int_in = 1'b0;
        wait_vld(v + 1, 600);
    endtask

    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        int_in = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        push_cfg();
        rst = 1'b0;
        rst_rel_cyc = cyc;
    endtask

    initial begin : stimulus
        burst_t b, b2;
        int     s, v;

        repeat (3) @(posedge clk);
        #1;
        push_cfg();
        rst = 1'b0;
        rst_rel_cyc = cyc;
        wait_cfg(400);

        // Stray done while idle; nothing may be issued with INT low.
        wait_cycles(5);
        stray_done = 1'b1;
        wait_cycles(1);
        stray_done = 1'b0;
        wait_cycles(20);
        chk("idle_no_wrt", wrt_cnt, 3);

        spi_lat = 3;
        for (int k = 0; k < 10; k++) b[k] = 8'(8'h10 + k);
        run_burst(b);
        chk("pattern_ptch", ptch, 16'h1110);
        chk("pattern_ay", ay, 16'h1918);

        for (int r = 0; r < 3; r++) begin
            spi_lat = $urandom_range(1, 6);
            run_burst(rand_burst());
        end

        // INT held high across two bursts.
        spi_lat = 2;
        b  = rand_burst();
        b2 = rand_burst();
        push_burst(b, 1'b1, 10);
        push_burst(b2, 1'b1, 10);
        s = wrt_cnt;
        v = vld_cnt;
        b2b_mode = 1'b1;
        int_in = 1'b1;
        first_rd_exp_cyc = cyc + 3;
        wait_wrt(s + 11, 400);
        int_in = 1'b0;
        b2b_mode = 1'b0;
        wait_vld(v + 2, 400);

        // Reset during RD_WAIT at idx 5; the in-flight done lands in WAIT_POR.
        spi_lat = 8;
        push_burst(rand_burst(), 1'b0, 6);
        s = wrt_cnt;
        int_in = 1'b1;
        wait_wrt(s + 6, 200);
        int_in = 1'b0;
        do_reset(2);
        wait_cycles(6);
        stray_done = 1'b1;
        wait_cycles(1);
        stray_done = 1'b0;
        spi_lat = 20;
        wait_cfg(400);

        spi_lat = $urandom_range(1, 6);
        run_burst(rand_burst());
        wait_cycles(30);

        chk("cmd_queue_empty", cmd_exp.size(), 0);
        chk("samp_queue_empty", samp_exp.size(), 0);
        chk("data_queue_empty", data_q.size(), 0);
        chk("wrt_total", wrt_cnt, 82);
        chk("vld_total", vld_cnt, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
